// File: rtl/pe_row_conv_ctrl.sv
// -----------------------------------------------------------------------------
// pe_row_conv_ctrl
//   Processing-element controller for a 1-D row convolution. It loads one
//   filter row (S weights) and one ifmap row (W activations) into local
//   scratchpads. For each of the W-S+1 output pixels it accepts an incoming
//   partial sum, runs S signed 8x8 MACs into a 24-bit accumulator (one per
//   cycle), and emits the updated partial sum downstream.
//
// Ports
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_cfg_valid/i_cfg_s/i_cfg_w    job start (accepted only when idle)
//   o_cfg_err                      one-cycle pulse on a rejected cfg
//   o_busy                         high whenever a job is in progress
//   i_filt_*  / o_filt_ready       filter weight load handshake
//   i_ifmap_* / o_ifmap_ready      activation load handshake
//   i_ipsum_* / o_ipsum_ready      incoming partial sum handshake
//   o_opsum_* / i_opsum_ready      updated partial sum handshake
// -----------------------------------------------------------------------------

// Combinational MAC: o_psum = i_psum + i_ifmap * i_filt (mod 2^24).
module pe_mac (
  input  logic signed [7:0]  i_ifmap,
  input  logic signed [7:0]  i_filt,
  input  logic        [23:0] i_psum,
  output logic        [23:0] o_psum
);
  logic signed [15:0] w_a;
  logic signed [15:0] w_b;
  logic signed [15:0] w_prod;

  // Widen before multiplying so -128*-128 = +16384 is exact in 16 bits.
  assign w_a    = $signed({{8{i_ifmap[7]}}, i_ifmap});
  assign w_b    = $signed({{8{i_filt[7]}}, i_filt});
  assign w_prod = w_a * w_b;
  assign o_psum = i_psum + {{8{w_prod[15]}}, w_prod};
endmodule

module pe_row_conv_ctrl #(
  parameter int FILT_DEPTH  = 8,
  parameter int IFMAP_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_valid,
  input  logic [3:0]  i_cfg_s,
  input  logic [4:0]  i_cfg_w,
  output logic        o_cfg_err,
  output logic        o_busy,
  input  logic [7:0]  i_filt_data,
  input  logic        i_filt_valid,
  output logic        o_filt_ready,
  input  logic [7:0]  i_ifmap_data,
  input  logic        i_ifmap_valid,
  output logic        o_ifmap_ready,
  input  logic [23:0] i_ipsum_data,
  input  logic        i_ipsum_valid,
  output logic        o_ipsum_ready,
  output logic [23:0] o_opsum_data,
  output logic        o_opsum_valid,
  input  logic        i_opsum_ready
);
  localparam int FA = (FILT_DEPTH  > 1) ? $clog2(FILT_DEPTH)  : 1;
  localparam int IA = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
  localparam logic [3:0] S_MAX = 4'(FILT_DEPTH);
  localparam logic [4:0] W_MAX = 5'(IFMAP_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_FILT  = 3'd1,
    ST_LOAD_IFMAP = 3'd2,
    ST_WAIT_PSUM  = 3'd3,
    ST_COMPUTE    = 3'd4,
    ST_OUTPUT     = 3'd5
  } state_t;

  state_t      r_state;
  logic [3:0]  r_s;
  logic [4:0]  r_w;
  logic [3:0]  r_k;
  logic [4:0]  r_i;
  logic [4:0]  r_j;
  logic [23:0] r_acc;
  logic        r_cfg_err;
  logic        r_busy;
  logic        r_filt_ready;
  logic        r_ifmap_ready;
  logic        r_ipsum_ready;
  logic        r_opsum_valid;
  logic [23:0] r_opsum_data;

  logic signed [7:0] r_filt_spad  [FILT_DEPTH];
  logic signed [7:0] r_ifmap_spad [IFMAP_DEPTH];

  logic          w_cfg_legal;
  logic          w_filt_xfer;
  logic          w_ifmap_xfer;
  logic          w_ipsum_xfer;
  logic          w_opsum_xfer;
  logic [4:0]    w_if_sum;
  logic [FA-1:0] w_k_idx;
  logic [IA-1:0] w_i_idx;
  logic [IA-1:0] w_if_idx;
  logic [23:0]   w_mac;

  assign w_cfg_legal  = (i_cfg_s != 4'd0) && (i_cfg_s <= S_MAX) &&
                        ({1'b0, i_cfg_s} <= i_cfg_w) && (i_cfg_w <= W_MAX);
  // Readies are registered copies of the state decode, so no valid->ready path.
  assign w_filt_xfer  = r_filt_ready  & i_filt_valid;
  assign w_ifmap_xfer = r_ifmap_ready & i_ifmap_valid;
  assign w_ipsum_xfer = r_ipsum_ready & i_ipsum_valid;
  assign w_opsum_xfer = r_opsum_valid & i_opsum_ready;

  // r_k doubles as the filter load index and the MAC tap index.
  assign w_if_sum = r_j + {1'b0, r_k};
  assign w_k_idx  = r_k[FA-1:0];
  assign w_i_idx  = r_i[IA-1:0];
  assign w_if_idx = w_if_sum[IA-1:0];

  pe_mac u_mac (
    .i_ifmap (r_ifmap_spad[w_if_idx]),
    .i_filt  (r_filt_spad[w_k_idx]),
    .i_psum  (r_acc),
    .o_psum  (w_mac)
  );

  // Scratchpad writes; contents survive reset on purpose.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_filt_xfer) begin
      r_filt_spad[w_k_idx] <= i_filt_data;
    end
    if (i_rst_n && w_ifmap_xfer) begin
      r_ifmap_spad[w_i_idx] <= i_ifmap_data;
    end
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_s           <= 4'd0;
      r_w           <= 5'd0;
      r_k           <= 4'd0;
      r_i           <= 5'd0;
      r_j           <= 5'd0;
      r_acc         <= 24'd0;
      r_cfg_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_filt_ready  <= 1'b0;
      r_ifmap_ready <= 1'b0;
      r_ipsum_ready <= 1'b0;
      r_opsum_valid <= 1'b0;
      r_opsum_data  <= 24'd0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            if (w_cfg_legal) begin
              r_s          <= i_cfg_s;
              r_w          <= i_cfg_w;
              r_k          <= 4'd0;
              r_busy       <= 1'b1;
              r_filt_ready <= 1'b1;
              r_state      <= ST_LOAD_FILT;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_LOAD_FILT: begin
          if (w_filt_xfer) begin
            if (r_k == r_s - 4'd1) begin
              r_k           <= 4'd0;
              r_i           <= 5'd0;
              r_filt_ready  <= 1'b0;
              r_ifmap_ready <= 1'b1;
              r_state       <= ST_LOAD_IFMAP;
            end else begin
              r_k <= r_k + 4'd1;
            end
          end
        end
        ST_LOAD_IFMAP: begin
          if (w_ifmap_xfer) begin
            if (r_i == r_w - 5'd1) begin
              r_j           <= 5'd0;
              r_ifmap_ready <= 1'b0;
              r_ipsum_ready <= 1'b1;
              r_state       <= ST_WAIT_PSUM;
            end else begin
              r_i <= r_i + 5'd1;
            end
          end
        end
        ST_WAIT_PSUM: begin
          if (w_ipsum_xfer) begin
            r_acc         <= i_ipsum_data;
            r_k           <= 4'd0;
            r_ipsum_ready <= 1'b0;
            r_state       <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_acc <= w_mac;
          r_k   <= r_k + 4'd1;
          // Last tap: publish the MAC result directly so opsum_data == acc.
          if (r_k == r_s - 4'd1) begin
            r_opsum_valid <= 1'b1;
            r_opsum_data  <= w_mac;
            r_state       <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (w_opsum_xfer) begin
            r_opsum_valid <= 1'b0;
            if (r_j == r_w - {1'b0, r_s}) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_j           <= r_j + 5'd1;
              r_ipsum_ready <= 1'b1;
              r_state       <= ST_WAIT_PSUM;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_filt_ready  <= 1'b0;
          r_ifmap_ready <= 1'b0;
          r_ipsum_ready <= 1'b0;
          r_opsum_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_err     = r_cfg_err;
  assign o_busy        = r_busy;
  assign o_filt_ready  = r_filt_ready;
  assign o_ifmap_ready = r_ifmap_ready;
  assign o_ipsum_ready = r_ipsum_ready;
  assign o_opsum_valid = r_opsum_valid;
  assign o_opsum_data  = r_opsum_data;
endmodule

// File: tb/tb_pe_row_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_row_conv_ctrl
//   Self-checking bench: directed and random row-convolution jobs compared
//   against a plain-arithmetic reference (sum of products, mod 2^24).
// -----------------------------------------------------------------------------
module tb_pe_row_conv_ctrl;
  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_cfg_valid;
  logic [3:0]  i_cfg_s;
  logic [4:0]  i_cfg_w;
  logic        o_cfg_err;
  logic        o_busy;
  logic [7:0]  i_filt_data;
  logic        i_filt_valid;
  logic        o_filt_ready;
  logic [7:0]  i_ifmap_data;
  logic        i_ifmap_valid;
  logic        o_ifmap_ready;
  logic [23:0] i_ipsum_data;
  logic        i_ipsum_valid;
  logic        o_ipsum_ready;
  logic [23:0] o_opsum_data;
  logic        o_opsum_valid;
  logic        i_opsum_ready;

  always #5 clk = ~clk;

  pe_row_conv_ctrl #(.FILT_DEPTH(8), .IFMAP_DEPTH(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_cfg_valid   (i_cfg_valid),
    .i_cfg_s       (i_cfg_s),
    .i_cfg_w       (i_cfg_w),
    .o_cfg_err     (o_cfg_err),
    .o_busy        (o_busy),
    .i_filt_data   (i_filt_data),
    .i_filt_valid  (i_filt_valid),
    .o_filt_ready  (o_filt_ready),
    .i_ifmap_data  (i_ifmap_data),
    .i_ifmap_valid (i_ifmap_valid),
    .o_ifmap_ready (o_ifmap_ready),
    .i_ipsum_data  (i_ipsum_data),
    .i_ipsum_valid (i_ipsum_valid),
    .o_ipsum_ready (o_ipsum_ready),
    .o_opsum_data  (o_opsum_data),
    .o_opsum_valid (o_opsum_valid),
    .i_opsum_ready (i_opsum_ready)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic signed [7:0] m_filt  [8];
  logic signed [7:0] m_ifmap [16];
  logic [23:0]       m_ipsum [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: ipsum + sum over taps of ifmap[j+k]*filt[k], truncated to 24 bits.
  function automatic logic [23:0] ref_psum(input int s, input int j);
    int acc;
    acc = int'(m_ipsum[j]);
    for (int k = 0; k < s; k++) acc += int'(m_filt[k]) * int'(m_ifmap[j + k]);
    return acc[23:0];
  endfunction

  function automatic logic rdy(input int which);
    case (which)
      0:       return o_filt_ready;
      1:       return o_ifmap_ready;
      default: return o_ipsum_ready;
    endcase
  endfunction

  // Present one beat on channel 0=filt, 1=ifmap, 2=ipsum; returns one
  // half-cycle after the accepting edge with valid dropped.
  task automatic send(input int which, input logic [23:0] data);
    int n;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    case (which)
      0:       begin i_filt_data  = data[7:0]; i_filt_valid  = 1'b1; end
      1:       begin i_ifmap_data = data[7:0]; i_ifmap_valid = 1'b1; end
      default: begin i_ipsum_data = data;      i_ipsum_valid = 1'b1; end
    endcase
    n = 0;
    while (!rdy(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_filt_valid  = 1'b0;
    i_ifmap_valid = 1'b0;
    i_ipsum_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_err"},   {31'd0, o_cfg_err}, 32'd0);
    check({tag, "_rdys"},  {29'd0, o_filt_ready, o_ifmap_ready, o_ipsum_ready}, 32'd0);
    check({tag, "_ovld"},  {31'd0, o_opsum_valid}, 32'd0);
    check({tag, "_odata"}, {8'd0, o_opsum_data}, 32'd0);
  endtask

  task automatic illegal_cfg(input int s, input int w);
    i_cfg_s = 4'(s); i_cfg_w = 5'(w); i_cfg_valid = 1'b1;
    @(negedge clk);
    i_cfg_valid = 1'b0;
    check("cfg_err_pulse", {31'd0, o_cfg_err}, 32'd1);
    check("cfg_err_busy", {31'd0, o_busy}, 32'd0);
    check("cfg_err_rdys", {29'd0, o_filt_ready, o_ifmap_ready, o_ipsum_ready}, 32'd0);
    @(negedge clk);
    check("cfg_err_clear", {31'd0, o_cfg_err}, 32'd0);
  endtask

  // Run a job from the model arrays; bp0 = backpressure cycles on output 0,
  // abort_j = output index whose COMPUTE is hit by reset (-1 for none).
  task automatic run_job(input int s, input int w, input int bp0, input int abort_j);
    int n;
    int bp;
    logic ok;
    logic [23:0] exp;
    i_cfg_s = 4'(s); i_cfg_w = 5'(w); i_cfg_valid = 1'b1;
    @(negedge clk);
    i_cfg_valid = 1'b0;
    check("busy_start", {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < s; k++) send(0, {16'd0, m_filt[k]});
    for (int i = 0; i < w; i++) send(1, {16'd0, m_ifmap[i]});
    for (int j = 0; j <= w - s; j++) begin
      send(2, m_ipsum[j]);
      if (j == abort_j) begin
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        check_all_zero("abort");
        i_opsum_ready = 1'b1;
        ok = 1'b1;
        repeat (12) begin
          @(negedge clk);
          if (o_opsum_valid || o_busy) ok = 1'b0;
        end
        i_opsum_ready = 1'b0;
        check("abort_quiet", {31'd0, ok}, 32'd1);
        return;
      end
      // Traffic that must be ignored while computing.
      i_filt_valid = 1'b1;  i_filt_data  = 8'($urandom);
      i_ifmap_valid = 1'b1; i_ifmap_data = 8'($urandom);
      i_cfg_valid = 1'b1;   i_cfg_s = 4'($urandom); i_cfg_w = 5'($urandom);
      n = 0;
      ok = 1'b1;
      while (!o_opsum_valid && n < 200) begin
        if (o_ipsum_ready || o_cfg_err) ok = 1'b0;
        @(negedge clk);
        n++;
      end
      i_filt_valid = 1'b0; i_ifmap_valid = 1'b0; i_cfg_valid = 1'b0;
      check("latency", n, s);
      check("compute_quiet", {31'd0, ok}, 32'd1);
      exp = ref_psum(s, j);
      bp = (j == 0) ? bp0 : $urandom_range(0, 2);
      repeat (bp) begin
        check("bp_valid", {31'd0, o_opsum_valid}, 32'd1);
        check("bp_data", {8'd0, o_opsum_data}, {8'd0, exp});
        check("bp_ipsum_rdy", {31'd0, o_ipsum_ready}, 32'd0);
        @(negedge clk);
      end
      check("opsum_valid", {31'd0, o_opsum_valid}, 32'd1);
      check("opsum_data", {8'd0, o_opsum_data}, {8'd0, exp});
      i_opsum_ready = 1'b1;
      @(negedge clk);
      i_opsum_ready = 1'b0;
      check("opsum_drop", {31'd0, o_opsum_valid}, 32'd0);
    end
    check("busy_end", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic randomize_data();
    for (int k = 0; k < 8; k++)  m_filt[k]  = 8'($urandom);
    for (int i = 0; i < 16; i++) m_ifmap[i] = 8'($urandom);
    for (int j = 0; j < 16; j++) m_ipsum[j] = 24'($urandom);
  endtask

  initial begin
    int s;
    int w;
    i_rst_n = 1'b0; i_cfg_valid = 1'b0; i_cfg_s = 4'd0; i_cfg_w = 5'd0;
    i_filt_data = 8'd0; i_filt_valid = 1'b0; i_ifmap_data = 8'd0; i_ifmap_valid = 1'b0;
    i_ipsum_data = 24'd0; i_ipsum_valid = 1'b0; i_opsum_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_rst_n = 1'b1;
    @(negedge clk);

    illegal_cfg(0, 5);
    illegal_cfg(6, 4);
    illegal_cfg(3, 17);
    illegal_cfg(9, 10);

    // S=3, W=5 ramp with 5 cycles of backpressure on the first output.
    for (int k = 0; k < 3; k++) m_filt[k] = 8'(k + 1);
    for (int i = 0; i < 5; i++) m_ifmap[i] = 8'(i + 1);
    for (int j = 0; j < 3; j++) m_ipsum[j] = 24'd0;
    run_job(3, 5, 5, -1);

    // Extreme product: -128 * -128 + 100.
    m_filt[0] = 8'h80; m_ifmap[0] = 8'h80; m_ipsum[0] = 24'd100;
    run_job(1, 1, 0, -1);

    // Wrap in both directions.
    m_filt[0] = 8'd1; m_filt[1] = 8'd0; m_ifmap[0] = 8'd1; m_ifmap[1] = 8'd0;
    m_ipsum[0] = 24'hFFFFFF;
    run_job(2, 2, 1, -1);
    m_filt[0] = 8'hFF; m_ipsum[0] = 24'h000000;
    run_job(2, 2, 0, -1);

    // Reset during COMPUTE of the second output, then a clean rerun.
    randomize_data();
    run_job(3, 6, 0, 1);
    run_job(3, 6, 2, -1);

    for (int t = 0; t < 10; t++) begin
      randomize_data();
      s = $urandom_range(1, 8);
      w = $urandom_range(s, 16);
      run_job(s, w, $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pe_row_conv_ctrl.md
Name: pe_row_conv_ctrl

Overview:
- Processing-element controller that sits directly upstream of the MAC datapath and feeds it.
- Buffers one filter row and one ifmap row in local scratchpads, accepts an incoming partial sum per output, and sequences one signed 8x8 MAC per cycle into a 24-bit accumulator.
- Emits the updated partial sum for each output pixel of a 1-D row convolution to the next PE or to the psum collector.
- Contains its own instance of the team's combinational MAC (ifmap, filter, psum -> updated_psum).

Parameters:
FILT_DEPTH, 8, filter scratchpad entries (max S)
IFMAP_DEPTH, 16, ifmap scratchpad entries (max W)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
cfg_valid  in  1  start pulse for a new row job; sampled only in IDLE
cfg_s  in  4  filter length S
cfg_w  in  5  ifmap length W
cfg_err  out  1  one-cycle pulse when a cfg is rejected
busy  out  1  high in every state except IDLE
filt_data  in  8  signed filter weight
filt_valid/filt_ready  in/out  1  filter load handshake
ifmap_data  in  8  signed activation
ifmap_valid/ifmap_ready  in/out  1  ifmap load handshake
ipsum_data  in  24  incoming partial sum (two's complement)
ipsum_valid/ipsum_ready  in/out  1  psum input handshake
opsum_data  out  24  updated partial sum
opsum_valid/opsum_ready  out/in  1  psum output handshake

Behaviour:
- Handshake rule: a transfer occurs on a cycle where valid and ready are both high.
  - Ready signals are decoded from state only and never depend on the same-cycle valid.
  - Once opsum_valid is high, it and opsum_data hold until the transfer completes.
- Reset (rst_n=0 at a clock edge): state=IDLE and all counters=0.
  - Outputs are all 0: cfg_err, busy, all readies, opsum_valid, opsum_data.
  - Scratchpad contents are not cleared.
  - Reset mid-job aborts the job; no partial output is emitted afterwards.
- FSM states: IDLE, LOAD_FILT, LOAD_IFMAP, WAIT_PSUM, COMPUTE, OUTPUT.
- IDLE:
  - Legal cfg: 1<=S<=FILT_DEPTH, S<=W<=IFMAP_DEPTH. On cfg_valid with a legal cfg, latch S and W and go to LOAD_FILT.
  - Illegal cfg: pulse cfg_err for 1 cycle and stay in IDLE.
- LOAD_FILT: filt_ready=1. Each transfer writes filt_spad[k], k=0..S-1. After the S-th transfer go to LOAD_IFMAP.
- LOAD_IFMAP: ifmap_ready=1. Each transfer writes ifmap_spad[i], i=0..W-1. After the W-th transfer set j=0 and go to WAIT_PSUM.
- WAIT_PSUM: ipsum_ready=1. On transfer, acc<=ipsum_data, k<=0, go to COMPUTE.
- COMPUTE: each cycle acc<=MAC(ifmap_spad[j+k], filt_spad[k], acc) and k<=k+1.
  - After the cycle with k=S-1, go to OUTPUT.
  - Takes exactly S cycles.
- OUTPUT: opsum_valid=1, opsum_data=acc. On transfer:
  - If j=W-S, go to IDLE.
  - Otherwise j<=j+1 and go to WAIT_PSUM.
- Latency: an ipsum transfer at cycle t gives opsum_valid high at t+S+1 (1 cycle WAIT_PSUM->COMPUTE entry plus S cycles of COMPUTE).
- Arithmetic:
  - Products are full signed 16-bit and sign-extended to 24 bits; -128*-128 = +16384 is exact.
  - The 24-bit accumulation wraps modulo 2^24, with no saturation and no overflow flag.
- Input gating:
  - cfg_valid is ignored while busy.
  - filt/ifmap/ipsum valids in non-accepting states are ignored (ready=0).
- Outputs per job: W-S+1; with S=W, exactly one output.

Test Plan:
- S=3, W=5, filt=[1,2,3], ifmap=[1,2,3,4,5], ipsum=0 each -> opsum 14, 20, 26, then busy=0. Each opsum appears exactly 4 cycles after its ipsum transfer.
- S=1, W=1, filt=[-128], ifmap=[-128], ipsum=100 -> single opsum 16484 (0x004064).
- S=2, W=2, filt=[1,0], ifmap=[1,0], ipsum=0xFFFFFF -> opsum 0x000000 (wrap). Repeat with filt=[-1,0], ipsum=0x000000 -> opsum 0xFFFFFF.
- Backpressure: hold opsum_ready=0 for 5 cycles in the first test -> opsum_valid and opsum_data stay stable. ipsum_ready stays 0 until the transfer completes; final results are unchanged.
- Illegal cfg with S=0, then S=6/W=4, then W=17 -> one cfg_err pulse each, busy stays 0, no readies asserted. cfg_valid during a job has no effect.
- rst_n=0 for 1 cycle during COMPUTE of the second output -> next cycle IDLE, all outputs 0, no opsum_valid. A fresh legal job afterwards completes correctly.
